// File: rtl/apb_i2s_host.sv
// APB initiator that configures the I2S transceiver, polls its FIFO status and
// moves samples between a valid/ready stream front-end and the Tx/Rx registers.
module apb_i2s_host #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [31:0] CTRL_OFS  = 32'h0,
    parameter logic [31:0] TX_OFS    = 32'h4,
    parameter logic [31:0] RX_OFS    = 32'h8,
    parameter logic [31:0] STAT_OFS  = 32'hC,
    parameter int unsigned POLL_GAP  = 4,
    parameter logic [31:0] STOP_WORD = 32'h0
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        start,
    input  logic [31:0] cfg_word,
    input  logic        stop,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [31:0] rx_data,
    input  logic        rx_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy,
    output logic [3:0]  status_q
);

    typedef enum logic [3:0] {
        IDLE, CFG_S, CFG_A, POLL_S, POLL_A, DECIDE, TX_S, TX_A,
        RX_S, RX_A, GAP, STOP_S, STOP_A
    } state_t;

    state_t      state, state_n;
    logic        stop_pending;
    logic [7:0]  gap_cnt;
    logic        rx_want, tx_go;
    logic        psel_n, penable_n, pwrite_n;
    logic [31:0] paddr_n, pwdata_n;

    // status_q = {Tx_full, Tx_empty, Rx_full, Rx_empty}
    assign rx_want = !status_q[0] && !rx_valid;
    assign tx_go   = tx_valid && !status_q[3];
    assign busy    = (state != IDLE);

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        tx_ready = 1'b0;
        case (state)
            IDLE:    if (start) state_n = CFG_S;
            CFG_S:   state_n = CFG_A;
            CFG_A:   state_n = POLL_S;
            POLL_S:  state_n = POLL_A;
            POLL_A:  state_n = DECIDE;
            DECIDE: begin
                if (stop_pending) begin
                    state_n = STOP_S;
                end else if (rx_want) begin
                    state_n = RX_S;
                end else if (tx_go) begin
                    tx_ready = 1'b1;
                    state_n  = TX_S;
                end else begin
                    state_n = GAP;
                end
            end
            TX_S:    state_n = TX_A;
            TX_A:    state_n = POLL_S;
            RX_S:    state_n = RX_A;
            RX_A:    state_n = POLL_S;
            GAP:     if (gap_cnt <= 8'd1) state_n = POLL_S;
            STOP_S:  state_n = STOP_A;
            STOP_A:  state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // APB outputs are registered from the next state so they line up with it
        psel_n    = 1'b0;
        penable_n = 1'b0;
        pwrite_n  = pwrite;
        paddr_n   = paddr;
        pwdata_n  = pwdata;
        case (state_n)
            CFG_S: begin
                psel_n   = 1'b1;
                pwrite_n = 1'b1;
                paddr_n  = BASE_ADDR + CTRL_OFS;
                pwdata_n = cfg_word;
            end
            POLL_S: begin
                psel_n   = 1'b1;
                pwrite_n = 1'b0;
                paddr_n  = BASE_ADDR + STAT_OFS;
            end
            TX_S: begin
                psel_n   = 1'b1;
                pwrite_n = 1'b1;
                paddr_n  = BASE_ADDR + TX_OFS;
                pwdata_n = tx_data;
            end
            RX_S: begin
                psel_n   = 1'b1;
                pwrite_n = 1'b0;
                paddr_n  = BASE_ADDR + RX_OFS;
            end
            STOP_S: begin
                psel_n   = 1'b1;
                pwrite_n = 1'b1;
                paddr_n  = BASE_ADDR + CTRL_OFS;
                pwdata_n = STOP_WORD;
            end
            CFG_A, POLL_A, TX_A, RX_A, STOP_A: begin
                psel_n    = 1'b1;
                penable_n = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= 32'h0;
            pwdata  <= 32'h0;
        end else begin
            psel    <= psel_n;
            penable <= penable_n;
            pwrite  <= pwrite_n;
            paddr   <= paddr_n;
            pwdata  <= pwdata_n;
        end
    end

    // A stop is only honoured in DECIDE, so any transfer in flight finishes first
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            stop_pending <= 1'b0;
        end else if (state == STOP_A) begin
            stop_pending <= 1'b0;
        end else if (stop && state != IDLE) begin
            stop_pending <= 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            gap_cnt <= 8'd0;
        end else if (state_n == GAP && state != GAP) begin
            gap_cnt <= 8'(POLL_GAP);
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt - 8'd1;
        end
    end

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            status_q <= 4'b0101;
        end else if (state == POLL_A) begin
            status_q <= prdata[3:0];
        end
    end

    // Holding register: survives stop, blocks further Rx reads until drained
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            rx_valid <= 1'b0;
            rx_data  <= 32'h0;
        end else if (state == RX_A) begin
            rx_valid <= 1'b1;
            rx_data  <= prdata;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_i2s_host.sv
// Scoreboard bench for apb_i2s_host: a small APB slave model answers reads and
// every non-poll transfer and delivered Rx word is matched against a queue.
module tb_apb_i2s_host;

    localparam logic [31:0] BASE   = 32'h100;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_TX   = BASE + 32'h4;
    localparam logic [31:0] A_RX   = BASE + 32'h8;
    localparam logic [31:0] A_STAT = BASE + 32'hC;

    logic        pclk = 1'b0, preset = 1'b0, start = 1'b0, stop = 1'b0;
    logic        tx_valid = 1'b0, rx_ready = 1'b0;
    logic [31:0] cfg_word = 32'h0, tx_data = 32'h0;
    logic        tx_ready, rx_valid, psel, penable, pwrite, busy;
    logic [31:0] rx_data, paddr, pwdata, prdata;
    logic [3:0]  status_q;

    logic [3:0]  stat = 4'b0101;
    logic [31:0] rx_word = 32'h0;
    int          errors = 0, checks = 0, txr_cnt = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;
    xfer_t       exp_q[$];
    logic [31:0] rx_q[$];
    xfer_t       mon_e;
    logic [31:0] mon_r;
    logic        prev_setup = 1'b0, prev_wr = 1'b0;
    logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;

    apb_i2s_host #(.BASE_ADDR(BASE), .POLL_GAP(4)) dut (
        .pclk(pclk), .preset(preset), .start(start), .cfg_word(cfg_word), .stop(stop),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .busy(busy), .status_q(status_q)
    );

    always #5 pclk = ~pclk;

    assign prdata = (paddr == A_STAT) ? {28'h0, stat} :
                    (paddr == A_RX)   ? rx_word : 32'h0;

    initial forever begin
        @(posedge pclk);
        cyc++;
    end

    initial forever begin
        @(negedge pclk);
        if (tx_ready) txr_cnt++;
    end

    // Monitor: protocol check on every access phase, scoreboard on non-poll transfers
    initial forever begin
        @(negedge pclk);
        if (!preset) begin
            prev_setup = 1'b0;
        end else begin
            if (psel && penable) begin
                checks++;
                if (!prev_setup || prev_addr !== paddr || prev_wr !== pwrite ||
                    (pwrite && prev_data !== pwdata)) begin
                    errors++;
                    $display("FAIL apb_setup: access addr=%h wr=%b data=%h, required setup addr=%h wr=%b data=%h setup=%b",
                             paddr, pwrite, pwdata, prev_addr, prev_wr, prev_data, prev_setup);
                end
                if (pwrite || paddr != A_STAT) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL apb_xfer: got wr=%b addr=%h data=%h, required no transfer", pwrite, paddr, pwdata);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (pwrite !== mon_e.wr || paddr !== mon_e.addr || (mon_e.wr && pwdata !== mon_e.data)) begin
                            errors++;
                            $display("FAIL apb_xfer: got wr=%b addr=%h data=%h, required wr=%b addr=%h data=%h",
                                     pwrite, paddr, pwdata, mon_e.wr, mon_e.addr, mon_e.data);
                        end
                    end
                end
            end
            if (rx_valid && rx_ready) begin
                checks++;
                if (rx_q.size() == 0) begin
                    errors++;
                    $display("FAIL rx_word: got %h, required no word", rx_data);
                end else begin
                    mon_r = rx_q.pop_front();
                    if (rx_data !== mon_r) begin
                        errors++;
                        $display("FAIL rx_word: got %h, required %h", rx_data, mon_r);
                    end
                end
            end
            prev_setup = psel && !penable;
            prev_addr  = paddr;
            prev_wr    = pwrite;
            prev_data  = pwdata;
        end
    end

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] w, input logic with_stop);
        tick();
        start = 1'b1; cfg_word = w; stop = with_stop;
        tick();
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic wait_poll_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (psel && penable && !pwrite && paddr == A_STAT) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tx_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite, tx_ready, busy, rx_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 000000", {psel, penable, pwrite, tx_ready, busy, rx_valid});
        end
        checks++;
        if (paddr !== 32'h0 || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got paddr=%h pwdata=%h, required 0/0", paddr, pwdata);
        end
        checks++;
        if (rx_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rx_data: got %h, required 0", rx_data);
        end
        checks++;
        if (status_q !== 4'b0101) begin
            errors++;
            $display("FAIL reset_status_q: got %b, required 0101", status_q);
        end
        tick();
        preset = 1'b1;
    endtask

    task automatic test_config;
        bit ok;
        exp_q.push_back('{1'b1, A_CTRL, 32'hA5});
        pulse_start(32'hA5, 1'b1);
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== A_CTRL || pwdata !== 32'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_setup: got sel/en/wr=%b addr=%h data=%h busy=%b, required 101 %h 000000a5 1",
                     {psel, penable, pwrite}, paddr, pwdata, busy, A_CTRL);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b111) begin
            errors++;
            $display("FAIL cfg_access: got sel/en/wr=%b, required 111", {psel, penable, pwrite});
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== A_STAT) begin
            errors++;
            $display("FAIL first_poll: got sel/en/wr=%b addr=%h, required 100 %h", {psel, penable, pwrite}, paddr, A_STAT);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL cfg_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_tx_full_gap;
        bit ok0, ok1, ok2;
        int n0;
        int unsigned t0, t1;
        wait_poll_a(ok0);
        stat = 4'b1001; tx_valid = 1'b1; tx_data = 32'h5555;
        n0 = txr_cnt;
        wait_poll_a(ok1);
        t0 = cyc;
        wait_poll_a(ok2);
        t1 = cyc;
        checks++;
        if (!(ok0 && ok1 && ok2) || (t1 - t0) != 7) begin
            errors++;
            $display("FAIL gap_period: got %0d cycles (ok=%b%b%b), required 7", t1 - t0, ok0, ok1, ok2);
        end
        checks++;
        if (txr_cnt != n0) begin
            errors++;
            $display("FAIL tx_full_ready: got %0d pulses, required 0", txr_cnt - n0);
        end
        tx_valid = 1'b0;
        stat = 4'b0101;
    endtask

    task automatic test_tx_push;
        bit ok;
        int n0;
        tick();
        n0 = txr_cnt;
        exp_q.push_back('{1'b1, A_TX, 32'h1234});
        tx_valid = 1'b1; tx_data = 32'h1234;
        wait_tx_ready(ok);
        @(posedge pclk); #1;
        tx_valid = 1'b0;
        @(negedge pclk);
        checks++;
        if (!ok || {psel, penable, pwrite} !== 3'b101 || paddr !== A_TX || pwdata !== 32'h1234) begin
            errors++;
            $display("FAIL tx_setup: got ok=%b sel/en/wr=%b addr=%h data=%h, required 1 101 %h 00001234",
                     ok, {psel, penable, pwrite}, paddr, pwdata, A_TX);
        end
        repeat (15) @(negedge pclk);
        checks++;
        if (txr_cnt - n0 != 1) begin
            errors++;
            $display("FAIL tx_ready_pulses: got %0d, required 1", txr_cnt - n0);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tx_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_rx_drain;
        bit ok;
        tick();
        rx_ready = 1'b0; rx_word = 32'hDEAD; stat = 4'b0100;
        exp_q.push_back('{1'b0, A_RX, 32'h0});
        rx_q.push_back(32'hDEAD);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge pclk);
            if (rx_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || rx_data !== 32'hDEAD) begin
            errors++;
            $display("FAIL rx_load: got valid=%b data=%h, required 1 0000dead", rx_valid, rx_data);
        end
        rx_word = 32'hF00D;
        tx_valid = 1'b1; tx_data = 32'hBEEF;
        exp_q.push_back('{1'b1, A_TX, 32'hBEEF});
        wait_tx_ready(ok);
        @(posedge pclk); #1;
        tx_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL backpressure_tx: got %0d pending, required 0", exp_q.size());
        end
        repeat (20) @(negedge pclk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 32'hDEAD) begin
            errors++;
            $display("FAIL rx_hold: got valid=%b data=%h, required 1 0000dead", rx_valid, rx_data);
        end
        stat = 4'b0101;
        repeat (16) @(negedge pclk);
        tick();
        rx_ready = 1'b1;
        @(negedge pclk);
        checks++;
        if (rx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rx_before_hs: got valid=%b, required 1", rx_valid);
        end
        @(posedge pclk); #1;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_after_hs: got valid=%b, required 0", rx_valid);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_priority;
        bit ok;
        wait_poll_a(ok);
        stat = 4'b0100; rx_word = 32'h77; tx_valid = 1'b1; tx_data = 32'h99;
        exp_q.push_back('{1'b0, A_RX, 32'h0});
        exp_q.push_back('{1'b1, A_TX, 32'h99});
        rx_q.push_back(32'h77);
        @(negedge pclk);
        checks++;
        if (!ok || tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_decide: got ok=%b tx_ready=%b, required 1 0", ok, tx_ready);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== A_RX) begin
            errors++;
            $display("FAIL prio_rx_first: got sel/en/wr=%b addr=%h, required 100 %h", {psel, penable, pwrite}, paddr, A_RX);
        end
        wait_tx_ready(ok);
        @(posedge pclk); #1;
        tx_valid = 1'b0;
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prio_drain: got %0d pending, required 0", exp_q.size());
        end
        stat = 4'b0101;
        repeat (16) @(negedge pclk);
        tick();
        rx_ready = 1'b1;
        for (int i = 0; i < 10 && rx_q.size() != 0; i++) @(negedge pclk);
        tick();
        rx_ready = 1'b0;
        checks++;
        if (rx_q.size() != 0) begin
            errors++;
            $display("FAIL prio_rx_out: got %0d pending words, required 0", rx_q.size());
        end
    endtask

    task automatic test_stop_mid_tx;
        bit ok;
        exp_q.push_back('{1'b1, A_TX, 32'hCAFE});
        exp_q.push_back('{1'b1, A_CTRL, 32'h0});
        tick();
        tx_valid = 1'b1; tx_data = 32'hCAFE;
        wait_tx_ready(ok);
        @(posedge pclk); #1;
        tx_valid = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        checks++;
        if (!ok || !(psel && penable && paddr == A_TX)) begin
            errors++;
            $display("FAIL stop_tx_access: got ok=%b sel/en=%b%b addr=%h, required 1 11 %h", ok, psel, penable, paddr, A_TX);
        end
        stop = 1'b1;
        @(posedge pclk); #1;
        stop = 1'b0;
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b100 || paddr !== A_STAT) begin
            errors++;
            $display("FAIL stop_poll: got sel/en/wr=%b addr=%h, required 100 %h", {psel, penable, pwrite}, paddr, A_STAT);
        end
        @(negedge pclk);
        @(negedge pclk);
        checks++;
        if (psel !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_decide: got psel=%b busy=%b, required 0 1", psel, busy);
        end
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== A_CTRL || pwdata !== 32'h0) begin
            errors++;
            $display("FAIL stop_write: got sel/en/wr=%b addr=%h data=%h, required 101 %h 00000000",
                     {psel, penable, pwrite}, paddr, pwdata, A_CTRL);
        end
        @(negedge pclk);
        @(negedge pclk);
        checks++;
        if (busy !== 1'b0 || psel !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: got busy=%b psel=%b, required 0 0", busy, psel);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stop_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_rx;
        bit ok;
        exp_q.push_back('{1'b1, A_CTRL, 32'h5A});
        rx_ready = 1'b0; stat = 4'b0100; rx_word = 32'h1111;
        pulse_start(32'h5A, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (psel && !penable && paddr == A_RX) begin
                ok = 1'b1;
                break;
            end
        end
        preset = 1'b0;
        #1;
        checks++;
        if (!ok || {psel, penable, rx_valid, busy} !== 4'b0000 || status_q !== 4'b0101) begin
            errors++;
            $display("FAIL reset_mid_rx: got ok=%b sel/en/rxv/busy=%b status=%b, required 1 0000 0101",
                     ok, {psel, penable, rx_valid, busy}, status_q);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_cfg_done: got %0d pending, required 0", exp_q.size());
        end
        repeat (2) tick();
        preset = 1'b1;
        stat = 4'b0101;
        exp_q.push_back('{1'b1, A_CTRL, 32'hA5});
        pulse_start(32'hA5, 1'b0);
        @(negedge pclk);
        checks++;
        if ({psel, penable, pwrite} !== 3'b101 || paddr !== A_CTRL || pwdata !== 32'hA5) begin
            errors++;
            $display("FAIL restart_cfg: got sel/en/wr=%b addr=%h data=%h, required 101 %h 000000a5",
                     {psel, penable, pwrite}, paddr, pwdata, A_CTRL);
        end
        exp_q.push_back('{1'b1, A_CTRL, 32'h0});
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_drain(ok);
        repeat (3) @(negedge pclk);
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL final_stop: got ok=%b busy=%b, required 1 0", ok, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_config();
        test_tx_full_gap();
        test_tx_push();
        test_rx_drain();
        test_priority();
        test_stop_mid_tx();
        test_reset_mid_rx();
        checks++;
        if (exp_q.size() != 0 || rx_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d/%0d pending, required 0/0", exp_q.size(), rx_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
